// File: rtl/multdiv_pkg.sv
// Shared constants and state encoding for the MultDiv sequencer.
package multdiv_pkg;

    localparam int ITERATIONS   = 32;
    localparam int MULT_LATENCY = ITERATIONS + 2;
    localparam int DIV_LATENCY  = ITERATIONS + 2;
    localparam int DIV0_LATENCY = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MULT,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } state_t;

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter shared by the multiply and divide datapaths.
// Latency: count updates on the clock edge; tc is combinational from the count.
// Backpressure: none; clear has priority over enable.
module multdiv_counter #(
    parameter int CNT_W = 6,
    parameter int TERM  = 31
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign tc = (cnt_q == CNT_W'(TERM));

endmodule

// File: rtl/multdiv_ctrl.sv
// MultDiv sequencer: iterative shift-add multiply / restoring divide with a sign fix-up step.
// Latency: WIDTH+2 cycles from start to RDY, 1 cycle for divide-by-zero; divider only with MULTDIV_DIV_EN.
// Backpressure: none; starts are accepted only in IDLE and ignored while an operation is in flight.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH = ITERATIONS,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mag_a_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               neg_q;
    logic               exc_q;

    logic               start_mult, start_div, div_zero;
    logic               cnt_clr, cnt_en, cnt_tc;
    logic [WIDTH-1:0]   abs_a, abs_b;
    logic [WIDTH:0]     mult_sum;
    logic [2*WIDTH-1:0] prod, prod_signed;
    logic [WIDTH-1:0]   fix_res;
    logic               fix_exc;

`ifdef MULTDIV_DIV_EN
    logic [WIDTH-1:0]   mag_b_q;
    logic               is_div_q;
    logic [WIDTH:0]     rem_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   rem_new;
`else
    logic               div_unused;
    assign div_unused = ctrl_DIV;
`endif

    assign start_mult = (state_q == ST_IDLE) && ctrl_MULT;
`ifdef MULTDIV_DIV_EN
    assign start_div  = (state_q == ST_IDLE) && ctrl_DIV && !ctrl_MULT;
`else
    assign start_div  = 1'b0;
`endif
    assign div_zero   = start_div && (data_operandB == '0);

    assign abs_a = data_operandA[WIDTH-1] ? (-data_operandA) : data_operandA;
    assign abs_b = data_operandB[WIDTH-1] ? (-data_operandB) : data_operandB;

    assign cnt_clr = (state_q == ST_IDLE);
    assign cnt_en  = (state_q == ST_MULT) || (state_q == ST_DIV);

    multdiv_counter #(
        .CNT_W (CNT_W),
        .TERM  (WIDTH - 1)
    ) u_counter (
        .clock (clock),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    // Multiply step: conditionally add |A| into the high half; the shift is applied on the register write.
    assign mult_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a_q} : {(WIDTH+1){1'b0}});

`ifdef MULTDIV_DIV_EN
    // Restoring divide step on {rem, quo} shifted left by one.
    assign rem_sh  = {hi_q, lo_q[WIDTH-1]};
    assign div_ge  = (rem_sh >= {1'b0, mag_b_q});
    assign rem_new = div_ge ? (rem_sh[WIDTH-1:0] - mag_b_q) : rem_sh[WIDTH-1:0];
`endif

    always_comb begin
        prod        = {hi_q, lo_q};
        prod_signed = neg_q ? (-prod) : prod;
        fix_res     = prod_signed[WIDTH-1:0];
        // Overflow unless the top WIDTH+1 bits are a pure sign extension.
        fix_exc     = ~((&prod_signed[2*WIDTH-1:WIDTH-1]) | ~(|prod_signed[2*WIDTH-1:WIDTH-1]));
`ifdef MULTDIV_DIV_EN
        if (is_div_q) begin
            fix_res = neg_q ? (-lo_q) : lo_q;
            // Only INT_MIN / -1 yields a positive quotient with the top bit set.
            fix_exc = ~neg_q & lo_q[WIDTH-1];
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_mult) begin
                    state_d = ST_MULT;
                end else if (div_zero) begin
                    state_d = ST_DONE;
                end else if (start_div) begin
                    state_d = ST_DIV;
                end
            end
            ST_MULT, ST_DIV: begin
                if (cnt_tc) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX:  state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            mag_a_q        <= '0;
            hi_q           <= '0;
            lo_q           <= '0;
            neg_q          <= 1'b0;
            exc_q          <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
`ifdef MULTDIV_DIV_EN
            mag_b_q        <= '0;
            is_div_q       <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            data_resultRDY <= (state_q == ST_DONE);
            case (state_q)
                ST_IDLE: begin
                    if (start_mult || start_div) begin
                        mag_a_q <= abs_a;
                        neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        hi_q    <= '0;
                        lo_q    <= start_mult ? abs_b : (div_zero ? '0 : abs_a);
                        exc_q   <= div_zero;
`ifdef MULTDIV_DIV_EN
                        mag_b_q  <= abs_b;
                        is_div_q <= start_div;
`endif
                    end
                end
                ST_MULT: begin
                    hi_q <= mult_sum[WIDTH:1];
                    lo_q <= {mult_sum[0], lo_q[WIDTH-1:1]};
                end
`ifdef MULTDIV_DIV_EN
                ST_DIV: begin
                    hi_q <= rem_new;
                    lo_q <= {lo_q[WIDTH-2:0], div_ge};
                end
`endif
                ST_FIX: begin
                    lo_q  <= fix_res;
                    exc_q <= fix_exc;
                end
                ST_DONE: begin
                    data_result    <= lo_q;
                    data_exception <= exc_q;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != ST_IDLE) || data_resultRDY;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Scoreboarded bench for multdiv_ctrl: directed cases, hazards, then random operations against an arithmetic model.
module tb_multdiv_ctrl;
`ifdef MULTDIV_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_operandA, data_operandB;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    typedef struct {
        logic [31:0] res;
        logic        exc;
        int          rdy_cyc;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    multdiv_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference arithmetic on 64-bit signed integers.
    task automatic model(input bit m, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output logic exc);
        longint sa, sb, p, q;
        sa = $signed(a);
        sb = $signed(b);
        if (m) begin
            p   = sa * sb;
            res = p[31:0];
            exc = (p != longint'($signed(p[31:0])));
        end else if (sb == 0) begin
            res = 32'h0;
            exc = 1'b1;
        end else if (sa == -64'sd2147483648 && sb == -64'sd1) begin
            res = 32'h8000_0000;
            exc = 1'b1;
        end else begin
            q   = sa / sb;
            res = q[31:0];
            exc = 1'b0;
        end
    endtask

    always @(negedge clock) begin
        exp_t e;
        if (data_resultRDY) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rdy: got rdy=1 result=%0h expected no completion (cycle %0d)",
                         data_result, cyc);
            end else begin
                e = exp_q.pop_front();
                check("result",      64'(data_result),    64'(e.res));
                check("exception",   64'(data_exception), 64'(e.exc));
                check("rdy_cycle",   64'(cyc),            64'(e.rdy_cyc));
                check("busy_at_rdy", 64'(busy),           64'(1));
            end
        end
    end

    task automatic run_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        if (m || (d && DIV_EN)) begin
            model(m, a, b, e.res, e.exc);
            e.rdy_cyc = cyc + 1 + ((!m && b == 32'h0) ? 1 : 34);
            exp_q.push_back(e);
        end
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: got %0d results pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge clock);
        @(negedge clock);
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h8000_0000;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h0;
            3:       v = 32'($urandom_range(0, 20));
            4:       v = 32'h0 - 32'($urandom_range(1, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        check("reset_result", 64'(data_result),    64'(0));
        check("reset_exc",    64'(data_exception), 64'(0));
        check("reset_rdy",    64'(data_resultRDY), 64'(0));
        check("reset_busy",   64'(busy),           64'(0));

        run_op(1, 0, 32'hFFFF_FFF9, 32'd6);          wait_done();
        run_op(1, 0, 32'h4000_0000, 32'd4);          wait_done();
        run_op(0, 1, 32'hFFFF_FFF9, 32'd2);          wait_done();
        run_op(0, 1, 32'd100, 32'd7);                wait_done();
        run_op(0, 1, 32'd100, 32'd0);                wait_done();
        run_op(0, 1, 32'h8000_0000, 32'hFFFF_FFFF);  wait_done();
        run_op(1, 1, 32'd3, 32'd5);                  wait_done();

        // A second start while busy must be ignored.
        run_op(1, 0, 32'h0000_1234, 32'h55);
        repeat (8) @(negedge clock);
        check("busy_mid_op", 64'(busy), 64'(1));
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd9;
        data_operandB = 32'd9;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        wait_done();

        // Leave non-zero outputs behind, then abort an operation with reset.
        run_op(1, 0, 32'h7FFF_FFFF, 32'd3);          wait_done();
        run_op(1, 0, 32'd5, 32'd5);
        repeat (18) @(negedge clock);
        reset = 1'b1;
        exp_q.delete();
        @(negedge clock);
        reset = 1'b0;
        check("abort_result", 64'(data_result),    64'(0));
        check("abort_exc",    64'(data_exception), 64'(0));
        check("abort_rdy",    64'(data_resultRDY), 64'(0));
        check("abort_busy",   64'(busy),           64'(0));
        repeat (40) @(negedge clock);
        run_op(1, 0, 32'd2, 32'd3);                  wait_done();

        for (int i = 0; i < 40; i++) begin
            int op;
            op = $urandom_range(0, 2);
            run_op(op != 1, op != 0, rnd_opnd(), rnd_opnd());
            wait_done();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multdiv_ctrl.md
Name: multdiv_ctrl

Overview:
- Sequencer for the MultDiv unit. It accepts one-cycle multiply or divide start pulses from the CPU pipeline and latches both operands.
- It runs an iterative 32-step shift-add multiplier or restoring divider, built from the unit's existing bitwise/adder primitives.
- It reports result, exception and ready back to the stall logic, and owns the shared product/remainder register.
- Only one operation is in flight at a time.

Parameters:
- WIDTH, 32: operand/result width; iteration count equals WIDTH.
- CNT_W, 6: width of the iteration counter; must hold WIDTH.

Ports:
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- ctrl_MULT, input, 1: start-multiply pulse; sampled when idle.
- ctrl_DIV, input, 1: start-divide pulse; sampled when idle.
- data_operandA, input, WIDTH: multiplicand/dividend; valid only in the start cycle.
- data_operandB, input, WIDTH: multiplier/divisor; valid only in the start cycle.
- data_result, output, WIDTH: signed result; held until the next start.
- data_exception, output, 1: overflow or divide-by-zero; valid with data_resultRDY and held after it.
- data_resultRDY, output, 1: one-cycle completion pulse.
- busy, output, 1: high from the cycle after start until the cycle data_resultRDY pulses, inclusive.

Behaviour:
- Reset (sync, active-high):
  - State goes to IDLE and the counter clears.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset mid-operation aborts with no RDY pulse.
- FSM states and transitions:
  - IDLE -> MULT on ctrl_MULT.
  - IDLE -> DIV on ctrl_DIV (and not ctrl_MULT).
  - IDLE -> DONE on ctrl_DIV with operandB==0.
  - MULT/DIV -> FIX when counter==WIDTH-1.
  - FIX -> DONE.
  - DONE -> IDLE.
- Simultaneous start: ctrl_MULT and ctrl_DIV high together: MULT wins.
- Starts while not IDLE (including in DONE) are ignored.
- Start cycle:
  - Operands are latched as magnitudes (two's-complement absolute value).
  - The sign of the result is recorded.
  - The counter clears.
- MULT iteration:
  - Form a 2*WIDTH product register {hi, lo=|B|}.
  - Each cycle: if lo[0], add |A| into hi (WIDTH+1 bit carry), then shift the pair right 1.
  - Exactly WIDTH cycles.
- DIV iteration:
  - Restoring division.
  - Each cycle: shift {rem, quo} left 1; trial = rem - |B|; if trial is non-negative, rem=trial and quo[0]=1.
  - Exactly WIDTH cycles.
- FIX (one cycle):
  - Apply sign: negate if the recorded sign is 1.
  - Compute the exception flag.
- MULT exception: the signed 2*WIDTH product does not fit in WIDTH bits, i.e. the upper WIDTH+1 bits are not all equal.
  - data_result is still the low WIDTH bits.
- DIV rules:
  - Truncate toward zero; the remainder is discarded.
  - INT_MIN / -1: exception=1, result=0x80000000.
- Divide-by-zero fast path: start cycle -> DONE.
  - RDY pulses the cycle after the start edge.
  - result=0, exception=1.
- Latency:
  - Normal: start sampled at edge N; data_resultRDY high after edge N+WIDTH+2 (34 cycles for WIDTH=32).
  - Outputs update on the same edge that raises RDY.
- data_result and data_exception hold their values from DONE until the next accepted start completes.

Optional Feature:
- Macro: MULTDIV_DIV_EN.
- Defined: full behaviour as above.
- Undefined:
  - Divider datapath and DIV state are compiled out.
  - ctrl_DIV is ignored.
  - The unit is multiply-only, with identical MULT timing.

Decomposition:
- Package multdiv_pkg holds:
  - the state encoding (IDLE, MULT, DIV, FIX, DONE);
  - the ITERATIONS constant (=WIDTH);
  - the MULT_LATENCY and DIV_LATENCY constants (WIDTH+2);
  - the DIV0_LATENCY constant (1).
- Sub-module multdiv_counter:
  - CNT_W-bit synchronous counter with clear, enable and terminal-count output.
  - Instantiated once and shared by both datapaths.

Test Plan:
- MULT A=-7 (0xFFFFFFF9), B=6 -> after 34 cycles: RDY pulse, result=0xFFFFFFD6, exception=0.
- MULT A=0x40000000, B=4 -> result=0x00000000, exception=1 (overflow).
- DIV A=-7, B=2 -> result=0xFFFFFFFD (-3), exception=0; DIV A=100, B=7 -> result=14.
- DIV A=100, B=0 -> RDY one cycle after start, result=0, exception=1.
- DIV A=0x80000000, B=0xFFFFFFFF -> result=0x80000000, exception=1.
- Hazards:
  - ctrl_MULT and ctrl_DIV both high with A=3, B=5 -> multiply, result=15.
  - A second ctrl_MULT at cycle 10 is ignored.
  - reset at cycle 20 -> no RDY pulse, all outputs 0, busy=0.
  - A following MULT 2*3 returns 6 in 34 cycles.
